// File: rtl/farbborg_pkg.sv
// Shared types and constants for the farbborg LED-cube frame-buffer scanner.
package farbborg_pkg;

    localparam int NUM_LAYERS      = 8;
    localparam int WORDS_PER_LAYER = 16;
    localparam int NUM_CHAINS      = 8;
    localparam int LAYER_W         = 3;
    localparam int WORD_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        CLK_HI,
        CLK_LO,
        LATCH,
        HOLD
    } scan_state_e;

    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [LAYER_W-1:0] layer);
        logic [NUM_LAYERS-1:0] v;
        v        = '0;
        v[layer] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/farbborg_pwm_compare.sv
// Threshold compare of the top PWM_BITS of each byte of a frame-buffer word,
// one result bit per driver chain. Purely combinational.
module farbborg_pwm_compare
    import farbborg_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic [8*NUM_CHAINS-1:0] word_i,
    input  logic [PWM_BITS-1:0]     threshold_i,
    output logic [NUM_CHAINS-1:0]   bits_o
);

    always_comb begin
        bits_o = '0;
        for (int unsigned k = 0; k < NUM_CHAINS; k++) begin
            bits_o[k] = (word_i[8*k+7 -: PWM_BITS] > threshold_i);
        end
    end

endmodule

// File: rtl/farbborg_scanner.sv
// LED-cube scanner: reads the frame buffer, shifts threshold-PWM planes into the
// driver chains, latches and holds each plane. Define FARBBORG_LAYER_BLANK_EN to blank layers while shifting.
module farbborg_scanner
    import farbborg_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int HOLD_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    output logic [LAYER_W+WORD_W-1:0]     ram_addr_o,
    input  logic [8*NUM_CHAINS-1:0]       ram_data_i,
    output logic [NUM_CHAINS-1:0]         sd_o,
    output logic                          sclk_o,
    output logic                          latch_o,
    output logic [NUM_LAYERS-1:0]         layer_o,
    output logic                          frame_done_o
);

    localparam int                     HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [PWM_BITS-1:0]    THR_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    scan_state_e             state_q, state_d;
    logic [LAYER_W-1:0]      layer_q, layer_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [PWM_BITS-1:0]     thr_q, thr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [NUM_CHAINS-1:0]   sd_q, sd_d;
    logic                    sclk_q, sclk_d;
    logic                    latch_q, latch_d;
    logic [NUM_LAYERS-1:0]   layer_sel_q, layer_sel_d;
    logic                    done_q, done_d;
    logic [NUM_CHAINS-1:0]   cmp_bits;

    farbborg_pwm_compare #(
        .PWM_BITS (PWM_BITS)
    ) u_cmp (
        .word_i      (ram_data_i),
        .threshold_i (thr_q),
        .bits_o      (cmp_bits)
    );

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        word_d      = word_q;
        thr_d       = thr_q;
        hold_d      = hold_q;
        sd_d        = sd_q;
        done_d      = 1'b0;
        layer_sel_d = layer_sel_q;

        unique case (state_q)
            IDLE:   if (enable_i) state_d = ADDR;
            ADDR:   state_d = WAIT;
            WAIT: begin
                sd_d    = cmp_bits;
                state_d = DATA;
            end
            DATA:   state_d = CLK_HI;
            CLK_HI: state_d = CLK_LO;
            CLK_LO: begin
                sd_d = '0;
                if (word_q == WORD_W'(WORDS_PER_LAYER - 1)) begin
                    state_d = LATCH;
                end else begin
                    word_d  = word_q + WORD_W'(1);
                    state_d = ADDR;
                end
            end
            LATCH: begin
                word_d  = '0;
                hold_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ADDR;
                    if (thr_q < THR_MAX) begin
                        thr_d = thr_q + PWM_BITS'(1);
                    end else begin
                        thr_d   = '0;
                        layer_d = layer_q + LAYER_W'(1);
                        // Frame boundary: the only place enable_i is honoured.
                        if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
                            done_d = 1'b1;
                            if (!enable_i) state_d = IDLE;
                        end
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d  = (state_d == CLK_HI);
        latch_d = (state_d == LATCH);

`ifdef FARBBORG_LAYER_BLANK_EN
        layer_sel_d = (state_d == HOLD) ? layer_onehot(layer_q) : '0;
`else
        if (state_q == LATCH) begin
            layer_sel_d = layer_onehot(layer_q);
        end else if (state_d == IDLE) begin
            layer_sel_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            word_q      <= '0;
            thr_q       <= '0;
            hold_q      <= '0;
            sd_q        <= '0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
            layer_sel_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            word_q      <= word_d;
            thr_q       <= thr_d;
            hold_q      <= hold_d;
            sd_q        <= sd_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
            layer_sel_q <= layer_sel_d;
            done_q      <= done_d;
        end
    end

    assign ram_addr_o   = {layer_q, word_q};
    assign sd_o         = sd_q;
    assign sclk_o       = sclk_q;
    assign latch_o      = latch_q;
    assign layer_o      = layer_sel_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_farbborg_scanner.sv
// Self-checking bench for farbborg_scanner: frame-position reference model plus
// hand-computed counts for the directed scenarios.
module tb_farbborg_scanner;

    localparam int PWM_BITS    = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int PLANES      = (1 << PWM_BITS) - 1;
    localparam int PLANE_LEN   = 80 + 1 + HOLD_CYCLES;
    localparam int LAYER_LEN   = PLANES * PLANE_LEN;
    localparam int FRAME_LEN   = 8 * LAYER_LEN;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [6:0]  ram_addr_o;
    logic [63:0] ram_data_i;
    logic [7:0]  sd_o;
    logic        sclk_o;
    logic        latch_o;
    logic [7:0]  layer_o;
    logic        frame_done_o;

    logic [63:0] mem [128];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    farbborg_scanner #(
        .PWM_BITS    (PWM_BITS),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .ram_addr_o   (ram_addr_o),
        .ram_data_i   (ram_data_i),
        .sd_o         (sd_o),
        .sclk_o       (sclk_o),
        .latch_o      (latch_o),
        .layer_o      (layer_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data_i <= mem[ram_addr_o];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame since the first ADDR cycle.
    typedef struct packed {
        logic        run;
        logic [31:0] pos;
        logic [7:0]  lit;
        logic        done;
    } mstate_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] sd;
        logic       sclk;
        logic       latch;
        logic [7:0] layer;
        logic       done;
    } exp_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(input mstate_t cur, input logic rst, input logic en);
        mstate_t n = cur;
        n.done = 1'b0;
        if (rst) begin
            n = '0;
        end else if (!cur.run) begin
            if (en) begin
                n.run = 1'b1;
                n.pos = 0;
            end
        end else begin
            n.pos = cur.pos + 1;
            if (n.pos == FRAME_LEN) begin
                n.done = 1'b1;
                n.pos  = 0;
                if (!en) begin
                    n.run = 1'b0;
                    n.lit = '0;
                end
            end
        end
        if (n.run && (n.pos % PLANE_LEN) > 80) n.lit = 8'(1 << (n.pos / LAYER_LEN));
        return n;
    endfunction

    function automatic logic [7:0] light(input logic [63:0] w, input int thr);
        logic [7:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            int lvl = int'((w >> (8 * k)) & 64'hFF);
            r[k] = ((lvl >> (8 - PWM_BITS)) > thr);
        end
        return r;
    endfunction

    function automatic exp_t expect_out(input mstate_t s);
        exp_t e = '0;
        int   lay, thr, off, w, ph;
        e.done  = s.done;
        e.layer = s.lit;
        if (s.run) begin
            lay = int'(s.pos) / LAYER_LEN;
            thr = (int'(s.pos) % LAYER_LEN) / PLANE_LEN;
            off = int'(s.pos) % PLANE_LEN;
            if (off < 80) begin
                w  = off / 5;
                ph = off % 5;
                e.addr = {lay[2:0], w[3:0]};
                if (ph >= 2) e.sd = light(mem[e.addr], thr);
                e.sclk = (ph == 3);
            end else if (off == 80) begin
                e.addr  = {lay[2:0], 4'hF};
                e.latch = 1'b1;
            end else begin
                e.addr = {lay[2:0], 4'h0};
            end
`ifdef FARBBORG_LAYER_BLANK_EN
            e.layer = (off > 80) ? 8'(1 << lay) : 8'h00;
`endif
        end
        return e;
    endfunction

    always @(posedge clk) m <= model_next(m, reset_i, enable_i);

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_t e;
            e = expect_out(m);
            check("ram_addr", 64'(ram_addr_o), 64'(e.addr));
            check("sd", 64'(sd_o), 64'(e.sd));
            check("sclk", 64'(sclk_o), 64'(e.sclk));
            check("latch", 64'(latch_o), 64'(e.latch));
            check("layer", 64'(layer_o), 64'(e.layer));
            check("frame_done", 64'(frame_done_o), 64'(e.done));
        end
    end

    task automatic reset_begin();
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_end();
        @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++) mem[a] = {$urandom, $urandom};
    endtask

    initial begin
        int n_sclk, n_latch, n_done, first_done, n_nz, n_hit, idle_bad, drop_at, got_hi;

        fill_random();
        reset_i  = 1'b1;
        enable_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en   = 1'b1;
        reset_i  = 1'b0;
        enable_i = 1'b1;

        // Random image, two full frames.
        n_sclk = 0; n_latch = 0; n_done = 0; first_done = -1;
        for (int i = 0; i < 2 * FRAME_LEN + 50; i++) begin
            @(negedge clk);
            if (i <= FRAME_LEN) begin
                if (sclk_o === 1'b1) n_sclk++;
                if (latch_o === 1'b1) n_latch++;
            end
            if (frame_done_o === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
        check("sclk_per_frame", 64'(n_sclk), 64'(384));
        check("latch_per_frame", 64'(n_latch), 64'(24));
        check("frame_done_time", 64'(first_done), 64'(2041));
        check("frame_done_count", 64'(n_done), 64'(2));

        // Word 0 of every layer at 0x80 in all bytes.
        reset_begin();
        for (int a = 0; a < 128; a++) mem[a] = (a % 16 == 0) ? 64'h8080_8080_8080_8080 : 64'h0;
        reset_end();
        n_nz = 0; n_hit = 0;
        for (int i = 0; i <= FRAME_LEN; i++) begin
            @(negedge clk);
            if (sd_o !== 8'h00) n_nz++;
            if (sd_o === 8'hFF) n_hit++;
        end
        check("w0_nonzero_cycles", 64'(n_nz), 64'(48));
        check("w0_all_chain_cycles", 64'(n_hit), 64'(48));

        // Single full-on byte: chain 3, layer 5, word 7.
        reset_begin();
        for (int a = 0; a < 128; a++) mem[a] = 64'h0;
        mem[{3'd5, 4'd7}] = 64'h0000_0000_FF00_0000;
        reset_end();
        n_nz = 0; n_hit = 0;
        for (int i = 0; i <= FRAME_LEN; i++) begin
            @(negedge clk);
            if (sd_o !== 8'h00) n_nz++;
            if (sd_o === 8'b0000_1000) n_hit++;
        end
        check("ch3_nonzero_cycles", 64'(n_nz), 64'(9));
        check("ch3_hit_cycles", 64'(n_hit), 64'(9));

        // Enable dropped somewhere in layer 2: frame completes, then idle.
        reset_begin();
        fill_random();
        reset_end();
        drop_at  = 1 + 2 * LAYER_LEN + int'($urandom_range(0, LAYER_LEN - 1));
        n_done   = 0;
        idle_bad = 0;
        for (int i = 0; i < FRAME_LEN + 300; i++) begin
            @(negedge clk);
            if (i == drop_at) enable_i = 1'b0;
            if (frame_done_o === 1'b1) n_done++;
            if (i > FRAME_LEN + 1) begin
                if (ram_addr_o !== 7'd0 || layer_o !== 8'd0 || sclk_o !== 1'b0 || latch_o !== 1'b0)
                    idle_bad++;
            end
        end
        check("drop_frame_done", 64'(n_done), 64'(1));
        check("drop_idle_quiet", 64'(idle_bad), 64'(0));

        // Reset during CLK_HI, then restart.
        enable_i = 1'b1;
        repeat (int'($urandom_range(100, 1500))) @(negedge clk);
        got_hi = 0;
        for (int k = 0; k < 20 && got_hi == 0; k++) begin
            @(negedge clk);
            if (sclk_o === 1'b1) got_hi = 1;
        end
        check("reached_clk_hi", 64'(got_hi), 64'(1));
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_sclk", 64'(sclk_o), 64'(0));
        check("rst_latch", 64'(latch_o), 64'(0));
        check("rst_layer", 64'(layer_o), 64'(0));
        reset_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("restart_addr", 64'(ram_addr_o), 64'(0));
        repeat (400) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
